// File: rtl/trs_clk_gen.sv
// trs_clk_gen: PLL-lock reset sequencer and NCO-based CPU clock enable for
// TRS-80 Model I timing. Everything runs on the single PLL clock; downstream
// logic qualifies on cpu_ce.
module trs_clk_gen #(
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned INC_NORMAL  = 37989716,
  parameter int unsigned INC_TURBO   = 151958864,
  parameter int unsigned LOCK_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pll_lock,
  input  logic        turbo,
  input  logic        wait_n,
  output logic        sys_rst_n,
  output logic        cpu_ce,
  output logic [15:0] ce_count
);

  localparam int unsigned CNT_W  = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned CE_W   = 16;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [ACC_W-1:0] INC_N    = ACC_W'(INC_NORMAL);
  localparam logic [ACC_W-1:0] INC_T    = ACC_W'(INC_TURBO);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Lock synchroniser flops
  logic lock_meta;
  logic lock_s;

  // Sequencer / NCO state
  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [ACC_W-1:0] acc_q,     acc_d;
  logic [ACC_W-1:0] inc_q,     inc_d;
  logic             pend_q,    pend_d;
  logic             ce_d;
  logic             rst_n_d;
  logic [CE_W-1:0]  ce_cnt_d;

  // Combinational helpers
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             fire;
  logic [ACC_W-1:0] inc_sel;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // State, counter, accumulator and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      acc_q     <= '0;
      inc_q     <= '0;
      pend_q    <= 1'b0;
      cpu_ce    <= 1'b0;
      sys_rst_n <= 1'b0;
      ce_count  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      inc_q     <= inc_d;
      pend_q    <= pend_d;
      cpu_ce    <= ce_d;
      sys_rst_n <= rst_n_d;
      ce_count  <= ce_cnt_d;
    end
  end

  // Next-state, NCO step, wait handling and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    inc_d    = inc_q;
    pend_d   = pend_q;
    ce_d     = 1'b0;
    rst_n_d  = 1'b0;
    ce_cnt_d = ce_count;

    inc_sel  = turbo ? INC_T : INC_N;
    sum      = {1'b0, acc_q} + {1'b0, inc_q};
    carry    = sum[ACC_W];
    fire     = 1'b0;

    case (state_q)
      ST_RESET: begin
        cnt_d   = '0;
        state_d = ST_WAIT_LOCK;
      end

      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = ST_STABLE;
        end
      end

      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Enter RUN from a clean accumulator with the current rate
          state_d = ST_RUN;
          acc_d   = '0;
          pend_d  = 1'b0;
          inc_d   = inc_sel;
          rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (!lock_s) begin
          // Lock lost: drop core reset and restart the NCO from scratch
          state_d  = ST_WAIT_LOCK;
          cnt_d    = '0;
          acc_d    = '0;
          pend_d   = 1'b0;
          ce_cnt_d = '0;
        end else begin
          rst_n_d = 1'b1;
          acc_d   = sum[ACC_W-1:0];
          // Rate changes only land on a period boundary
          if (carry) begin
            inc_d = inc_sel;
          end
          // Carries during a wait collapse into a single pending pulse
          fire   = wait_n && (carry || pend_q);
          pend_d = !wait_n && (carry || pend_q);
          ce_d   = fire;
          if (fire) begin
            ce_cnt_d = ce_count + CE_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

endmodule
